// File: rtl/pipe_pkg.sv
// Shared widths, opcode constants and payload sizing for the ID/EX stage.
package pipe_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned RA_W   = 3;

  localparam logic [OPC_W-1:0] OPC_NOP = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  function automatic int unsigned PAYLOAD_W(input int unsigned opc_w,
                                            input int unsigned num_src,
                                            input int unsigned data_w,
                                            input int unsigned ra_w);
    return opc_w + num_src * (data_w + ra_w) + ra_w + 1;
  endfunction

endpackage

// File: rtl/pipe_id_ex_skid_if.sv
// ID-side and EX-side handshake plus payload bundle for pipe_id_ex_skid.
interface pipe_id_ex_skid_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned RA_W    = 3,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [OPC_W-1:0]          opcode_in;
  logic [NUM_SRC*DATA_W-1:0] src_data_in;
  logic [NUM_SRC*RA_W-1:0]   src_addr_in;
  logic [RA_W-1:0]           rd_in;
  logic                      rd_we_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [OPC_W-1:0]          opcode_out;
  logic [NUM_SRC*DATA_W-1:0] src_data_out;
  logic [NUM_SRC*RA_W-1:0]   src_addr_out;
  logic [RA_W-1:0]           rd_out;
  logic                      rd_we_out;
  logic [1:0]                occupancy;
  logic [CNT_W-1:0]          bubble_cnt;

  modport master (
    output flush, in_valid, opcode_in, src_data_in, src_addr_in, rd_in, rd_we_in, out_ready,
    input  in_ready, out_valid, opcode_out, src_data_out, src_addr_out, rd_out, rd_we_out,
           occupancy, bubble_cnt
  );

  modport slave (
    input  flush, in_valid, opcode_in, src_data_in, src_addr_in, rd_in, rd_we_in, out_ready,
    output in_ready, out_valid, opcode_out, src_data_out, src_addr_out, rd_out, rd_we_out,
           occupancy, bubble_cnt
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Two-slot FIFO skid buffer over a flat payload; MAIN drives the output, SKID absorbs overflow.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   occupancy_o
);

  occ_e         state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         in_xfer, out_xfer;

  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign in_ready_o  = in_ready_q;
  assign occupancy_o = state_q;
  assign in_xfer     = in_valid_i && in_ready_q;
  assign out_xfer    = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // An output transfer this cycle still completes; everything else is dropped.
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data_i;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_d  = in_data_i;
            state_d = TWO;
          end else if (!in_xfer && out_xfer) begin
            main_d  = '0;
            state_d = EMPTY;
          end else if (in_xfer && out_xfer) begin
            main_d  = in_data_i;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/pipe_id_ex_skid.sv
// ID/EX pipeline stage: packs decode fields into the skid buffer and counts EX bubble cycles.
module pipe_id_ex_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = pipe_pkg::DATA_W,
  parameter int unsigned OPC_W   = pipe_pkg::OPC_W,
  parameter int unsigned RA_W    = pipe_pkg::RA_W,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
) (
  input logic             clk,
  input logic             rst,
  pipe_id_ex_skid_if.slave bus
);

  localparam int unsigned PW = PAYLOAD_W(OPC_W, NUM_SRC, DATA_W, RA_W);

  logic [PW-1:0]    in_pl, out_pl;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  assign in_pl = {bus.opcode_in, bus.src_data_in, bus.src_addr_in, bus.rd_in, bus.rd_we_in};
  assign {bus.opcode_out, bus.src_data_out, bus.src_addr_out, bus.rd_out, bus.rd_we_out} = out_pl;

  pipe_skid_buf #(.W(PW)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.flush),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (in_pl),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_pl),
    .occupancy_o (bus.occupancy)
  );

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!bus.out_valid && bus.out_ready && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) bubble_cnt_q <= '0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: doc/pipe_id_ex_skid.md
# pipe_id_ex_skid

Parametrised ID/EX pipeline stage with a valid/ready handshake and a two-entry skid buffer, so EX back-pressure never reaches ID combinationally. It carries the decoded opcode, NUM_SRC source operands with their register addresses, and the destination register plus write-enable. It supports synchronous flush (bubble insertion) and a saturating bubble counter for performance monitoring. It sits between the decode/hazard unit and the EX/forwarding logic.

## Interface
- DATA_W, 8, operand width
- OPC_W, 4, opcode width
- RA_W, 3, register-address width
- NUM_SRC, 2, source operand channels (≥1)
- CNT_W, 16, bubble counter width
- clk  in  1  rising-edge clock
- rst  in  1  reset; **synchronous, active-high**
- flush  in  1  kill all held entries (synchronous)
- in_valid  in  1  ID offers an instruction
- in_ready  out  1  stage can accept; registered
- opcode_in  in  OPC_W  decoded opcode
- src_data_in  in  NUM_SRC*DATA_W  operand values; channel k at [k*DATA_W +: DATA_W]
- src_addr_in  in  NUM_SRC*RA_W  source register addresses, same packing
- rd_in  in  RA_W  destination register
- rd_we_in  in  1  destination write enable
- out_valid  out  1  EX-side instruction valid
- out_ready  in  1  EX accepts
- opcode_out, src_data_out, src_addr_out, rd_out, rd_we_out  out  same widths as inputs  registered payload
- occupancy  out  2  held entries (0..2)
- bubble_cnt  out  CNT_W  saturating count of bubble cycles

## Operation
- Two slots: MAIN drives the outputs; SKID holds the overflow entry. Strict FIFO order.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = !skid_full, taken from a register with no combinational path from out_ready.
- States, encoded by occupancy:
  - EMPTY(0): input transfer → ONE.
  - ONE(1): input with no output → TWO (new entry to SKID). Output with no input → EMPTY. Both → ONE (MAIN loads the input).
  - TWO(2): in_ready=0. Output → ONE (SKID moves to MAIN, SKID cleared).
- Flush:
  - An output transfer in the flush cycle completes normally.
  - All remaining entries are cleared, and any input offered in the flush cycle is discarded.
  - Next cycle: occupancy=0, out_valid=0, in_ready=1.
  - flush has priority over every other transition except rst.
- Empty slots hold an all-zero payload, so opcode 0 is a NOP and rd_we_out=0. out_* is therefore 0 whenever out_valid=0.
- bubble_cnt increments in every cycle with out_valid=0 && out_ready=1, saturates at 2^CNT_W−1, and never wraps.

## Timing
- Reset (rst=1 at a clock edge), next cycle: out_valid=0, all payload outputs 0, occupancy=0, in_ready=1, bubble_cnt=0.
- A reset mid-operation drops all held entries. rst overrides flush.
- Latency: input transfer at edge N → out_valid=1 with that payload after edge N (one cycle).
- Throughput: 1 instruction/cycle while out_ready=1; occupancy stays ≤1.
- out_ready falling: at most one further input is accepted (into SKID). in_ready drops the cycle after SKID fills.
- out_ready rising from TWO: the SKID entry appears on the outputs the cycle after the MAIN transfer. in_ready returns to 1 in that same cycle.
- in_valid=1 while in_ready=0 has no effect. The payload on the inputs is ignored.
- Flush and out_ready=1 in the same cycle with occupancy=2: MAIN transfers, SKID is discarded, occupancy becomes 0.

## Structure
- Package pipe_pkg holds:
  - default width constants (DATA_W, OPC_W, RA_W)
  - OPC_NOP = 0
  - a PAYLOAD_W helper function (OPC_W + NUM_SRC*(DATA_W+RA_W) + RA_W + 1)
- Sub-module pipe_skid_buf: generic two-slot skid buffer over a flat PAYLOAD_W vector, with flush. It owns all the state logic.
- The top level packs and unpacks fields and owns bubble_cnt.

## Test plan
- Reset: hold rst for 2 cycles with random inputs → out_valid=0, payload 0, in_ready=1, occupancy=0, bubble_cnt=0.
- Streaming: out_ready=1, 8 back-to-back inputs opcode=1..8 → outputs opcode 1..8 one cycle later each, occupancy ≤1, in_ready stays 1.
- Back-pressure: out_ready=0 after opcode=3 is accepted, then offer 4 and 5 → 4 goes to SKID, in_ready=0, 5 held upstream. Release out_ready → 3, 4, 5 emerge in order with no loss or duplication.
- Flush at occupancy=2 with out_ready=1, opcode_in=9 offered → MAIN transfers once, 9 and the SKID entry never appear. Next cycle occupancy=0 and out_* all zero.
- Bubble counter: CNT_W=4, idle input, out_ready=1 for 20 cycles → bubble_cnt stops at 15. Repeat with rst asserted mid-count → next cycle 0.
- NUM_SRC=3, DATA_W=16: channel-distinct values (0x1111, 0x2222, 0x3333; addresses 1, 2, 3) → each reappears in its own slice unchanged.
